// File: rtl/fm_nco.sv
// fm_nco: phase-accumulator FM modulator.
//
// Each RUN cycle the phase accumulator advances by a registered increment
// equal to the captured carrier word plus the sign-extended, left-shifted
// audio sample. The accumulator MSB, registered, drives the RF pin.
//
// Ports:
//   clock         rising-edge clock (109.5 MHz PLL output)
//   reset_n       asynchronous active-low reset
//   enable        run request (PLL locked AND user enable upstream)
//   carrier_word  centre-frequency phase increment, captured in START only
//   sample        signed two's-complement audio sample
//   sample_valid  sample is presented
//   sample_ready  block accepts a sample this cycle (high exactly in RUN)
//   running       FSM is in RUN
//   phase_out     top 8 bits of the phase accumulator
//   rf_out        registered accumulator MSB
//   state_dbg     current FSM state encoding (IDLE=0, START=1, RUN=2)
//
// Handshake: a sample transfers on any rising edge where sample_valid and
// sample_ready are both high. sample_ready depends only on the FSM state,
// never on sample_valid, so upstream may hold a sample indefinitely until
// RUN is reached; without a transfer the last sample keeps being used.
module fm_nco #(
  parameter int ACC_WIDTH    = 32,
  parameter int SAMPLE_WIDTH = 16,
  parameter int DEV_SHIFT    = 8
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [ACC_WIDTH-1:0]    carrier_word,
  input  logic [SAMPLE_WIDTH-1:0] sample,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic                    running,
  output logic [7:0]              phase_out,
  output logic                    rf_out,
  output logic [1:0]              state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [ACC_WIDTH-1:0]    carrier_q;
  logic [SAMPLE_WIDTH-1:0] sample_q;
  logic [ACC_WIDTH-1:0]    inc_q;
  logic [ACC_WIDTH-1:0]    phase;
  logic [ACC_WIDTH-1:0]    deviation;
  logic                    handshake;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. START always lasts one cycle; a dropped enable is
  // handled by RUN on the following cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = START;
      START:   state_next = RUN;
      RUN:     if (!enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign running      = (state == RUN);
  assign sample_ready = running;
  assign state_dbg    = state;
  assign handshake    = sample_valid & sample_ready;

  // Sign-extend to the accumulator width, then shift; bits shifted past the
  // top are discarded, giving modulo-2^ACC_WIDTH deviation.
  assign deviation = {{(ACC_WIDTH-SAMPLE_WIDTH){sample_q[SAMPLE_WIDTH-1]}}, sample_q}
                     << DEV_SHIFT;

  // Datapath. The sample -> inc_q -> phase -> rf_out pipeline gives the
  // fixed latency of one edge per stage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      carrier_q <= '0;
      sample_q  <= '0;
      inc_q     <= '0;
      phase     <= '0;
      rf_out    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sample_q <= '0;
          inc_q    <= '0;
          phase    <= '0;
          rf_out   <= 1'b0;
        end
        START: begin
          carrier_q <= carrier_word;
          sample_q  <= '0;
        end
        RUN: begin
          if (!enable) begin
            // carrier_q deliberately kept; it is reloaded on the next START.
            sample_q <= '0;
            inc_q    <= '0;
            phase    <= '0;
            rf_out   <= 1'b0;
          end else begin
            if (handshake) begin
              sample_q <= sample;
            end
            inc_q  <= carrier_q + deviation;
            phase  <= phase + inc_q;
            rf_out <= phase[ACC_WIDTH-1];
          end
        end
        default: begin
          sample_q <= '0;
          inc_q    <= '0;
          phase    <= '0;
          rf_out   <= 1'b0;
        end
      endcase
    end
  end

  assign phase_out = phase[ACC_WIDTH-1 -: 8];

endmodule

// File: tb/tb_fm_nco.sv
// Testbench for fm_nco: directed stimulus, a timing-rule model of the
// modulator kept as per-edge histories, a per-cycle compare process and
// hand-computed literal expectations.
module tb_fm_nco;

  localparam int AW = 32;
  localparam int SW = 16;
  localparam int DS = 8;

  // ---------------- clock / reset ----------------
  logic          clock = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [AW-1:0] carrier_word;
  logic [SW-1:0] sample;
  logic          sample_valid;
  logic          sample_ready;
  logic          running;
  logic [7:0]    phase_out;
  logic          rf_out;
  logic [1:0]    state_dbg;

  always #5 clock = ~clock;

  fm_nco #(.ACC_WIDTH(AW), .SAMPLE_WIDTH(SW), .DEV_SHIFT(DS)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (enable),
    .carrier_word (carrier_word),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .running      (running),
    .phase_out    (phase_out),
    .rf_out       (rf_out),
    .state_dbg    (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // Histories indexed by edges since the START edge (index 0 = START edge):
  //   sm_hist[j] = sample in force after edge j
  //   ph_hist[j] = accumulator value after edge j
  // Spec timing: the increment in force after edge j is carrier plus the
  // deviation of the sample in force after edge j-1 (none before edge 1);
  // the accumulator after edge j+1 is the one after edge j plus that
  // increment; rf_out after edge j is the accumulator MSB after edge j-1.
  bit          m_run   = 1'b0;
  bit          m_start = 1'b0;
  int          k       = 0;
  logic [31:0] m_carrier = '0;
  logic [31:0] ph_hist[$];
  logic [15:0] sm_hist[$];

  function automatic logic [31:0] dev_of(input logic [15:0] s);
    logic [31:0] x;
    x = {{16{s[15]}}, s};
    return x << DS;
  endfunction

  function automatic logic [31:0] inc_after(input int j);
    if (j < 1) return 32'h0;
    return m_carrier + dev_of(sm_hist[j-1]);
  endfunction

  function automatic logic [31:0] model_delta();
    if (k < 1) return 32'h0;
    return ph_hist[k] - ph_hist[k-1];
  endfunction

  task automatic model_step();
    logic [15:0] ns;
    logic [31:0] np;
    if (!reset_n) begin
      m_run = 1'b0; m_start = 1'b0; k = 0;
      ph_hist.delete(); sm_hist.delete();
    end else if (m_start) begin
      m_start = 1'b0; m_run = 1'b1; k = 0;
      m_carrier = carrier_word;
      ph_hist.delete(); sm_hist.delete();
      ph_hist.push_back(32'h0);
      sm_hist.push_back(16'h0);
    end else if (m_run) begin
      if (!enable) begin
        m_run = 1'b0;
        ph_hist.delete(); sm_hist.delete();
      end else begin
        ns = sample_valid ? sample : sm_hist[k];
        np = ph_hist[k] + inc_after(k);
        ph_hist.push_back(np);
        sm_hist.push_back(ns);
        k++;
      end
    end else if (enable) begin
      m_start = 1'b1;
    end
  endtask

  initial forever begin
    @(posedge clock or negedge reset_n);
    model_step();
  end

  // ---------------- compare process ----------------
  task automatic compare_step();
    logic [31:0] ph;
    logic [31:0] prev;
    logic [1:0]  est;
    logic        erf;
    ph   = (m_run) ? ph_hist[k] : 32'h0;
    prev = (m_run && k >= 1) ? ph_hist[k-1] : 32'h0;
    erf  = prev[31];
    est  = m_start ? 2'd1 : (m_run ? 2'd2 : 2'd0);
    chk("running",      {31'h0, running},      {31'h0, m_run});
    chk("sample_ready", {31'h0, sample_ready}, {31'h0, m_run});
    chk("phase_out",    {24'h0, phase_out},    {24'h0, ph[31:24]});
    chk("rf_out",       {31'h0, rf_out},       {31'h0, erf});
    chk("state_dbg",    {30'h0, state_dbg},    {30'h0, est});
  endtask

  initial forever begin
    @(negedge clock);
    compare_step();
  end

  // ---------------- driver tasks ----------------
  task automatic wait_running(input string name);
    int n;
    n = 0;
    while (!running && n < 10) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (!running) begin
      errors++;
      $display("FAIL %s: running never rose within 10 cycles", name);
    end
  endtask

  task automatic restart(input logic [31:0] cw, input string name);
    enable = 1'b0;
    @(negedge clock);
    carrier_word = cw;
    enable = 1'b1;
    wait_running(name);
  endtask

  task automatic one_sample(input logic [15:0] s);
    sample = s;
    sample_valid = 1'b1;
    @(negedge clock);
    sample_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] pc_seq [4];

  initial begin
    int ones;
    int toggles;
    logic [7:0] prev_po;
    logic [7:0] d;
    logic prev_rf;

    pc_seq[0] = 8'h40; pc_seq[1] = 8'h80; pc_seq[2] = 8'hC0; pc_seq[3] = 8'h00;
    reset_n = 1'b0; enable = 1'b0; sample_valid = 1'b0;
    sample = '0; carrier_word = '0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Pure carrier: phase_out 00,00 then 40,80,C0,00 repeating.
    carrier_word = 32'h4000_0000;
    enable = 1'b1;
    wait_running("pc_start");
    chk("pc_s0", {24'h0, phase_out}, 32'h00);
    @(negedge clock);
    chk("pc_s1", {24'h0, phase_out}, 32'h00);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk("pc_seq", {24'h0, phase_out}, {24'h0, pc_seq[i % 4]});
    end
    ones = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      ones += int'(rf_out);
    end
    chk("pc_duty", ones, 8);

    // Carrier capture: a new word in RUN does not change the step.
    carrier_word = 32'h2000_0000;
    prev_po = phase_out;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      d = phase_out - prev_po;
      chk("cap_step", {24'h0, d}, 32'h40);
      prev_po = phase_out;
    end
    enable = 1'b0;
    @(negedge clock);
    chk("cap_off_run", {31'h0, running}, 32'h0);
    chk("cap_off_ph",  {24'h0, phase_out}, 32'h0);
    chk("cap_off_rf",  {31'h0, rf_out}, 32'h0);
    enable = 1'b1;
    wait_running("cap_restart");
    @(negedge clock);
    chk("cap_ph1", {24'h0, phase_out}, 32'h00);
    @(negedge clock);
    chk("cap_ph2", {24'h0, phase_out}, 32'h20);
    @(negedge clock);
    chk("cap_ph3", {24'h0, phase_out}, 32'h40);

    // Deviation and latency: 7FFF << 8 on carrier 1000_0000.
    restart(32'h1000_0000, "dev_start");
    repeat (3) @(negedge clock);
    one_sample(16'h7FFF);
    @(negedge clock);
    chk("dev_pre", model_delta(), 32'h1000_0000);
    @(negedge clock);
    chk("dev_delta", model_delta(), 32'h107F_FF00);
    chk("dev_inc",   inc_after(k),  32'h107F_FF00);
    repeat (20) @(negedge clock);

    // Negative sample and wrap.
    restart(32'h0000_0100, "neg_start");
    repeat (2) @(negedge clock);
    one_sample(16'h8000);
    @(negedge clock);
    @(negedge clock);
    chk("neg_delta", model_delta(), 32'hFF80_0100);
    toggles = 0;
    prev_rf = rf_out;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clock);
      if (rf_out !== prev_rf) toggles++;
      prev_rf = rf_out;
    end
    chk("neg_toggle", {31'h0, (toggles >= 2)}, 32'h1);

    // Handshake gating: valid held through IDLE and START.
    enable = 1'b0;
    sample = 16'h1234;
    sample_valid = 1'b1;
    @(negedge clock);
    chk("hs_idle_rdy", {31'h0, sample_ready}, 32'h0);
    carrier_word = 32'h0100_0000;
    repeat (2) begin
      @(negedge clock);
      chk("hs_idle_rdy", {31'h0, sample_ready}, 32'h0);
    end
    enable = 1'b1;
    @(negedge clock);
    chk("hs_start_state", {30'h0, state_dbg}, 32'h1);
    chk("hs_start_rdy",   {31'h0, sample_ready}, 32'h0);
    @(negedge clock);
    chk("hs_run", {31'h0, running}, 32'h1);
    @(negedge clock);
    sample_valid = 1'b0;
    sample = 16'h0000;
    repeat (4) @(negedge clock);
    chk("hs_hold",  {16'h0, sm_hist[k]}, 32'h0000_1234);
    chk("hs_delta", model_delta(), 32'h0112_3400);

    // Asynchronous reset mid-RUN, then idle with enable low.
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_running", {31'h0, running},      32'h0);
    chk("rst_ready",   {31'h0, sample_ready}, 32'h0);
    chk("rst_phase",   {24'h0, phase_out},    32'h0);
    chk("rst_rf",      {31'h0, rf_out},       32'h0);
    @(negedge clock);
    enable = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      chk("idle_quiet", {running, sample_ready, rf_out, phase_out}, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fm_nco.md
# fm_nco

Phase-accumulator FM modulator clocked directly from the 109.5 MHz PLL output, and gated by the PLL lock indication through the reset and enable inputs. It accepts signed audio samples over a valid/ready handshake. Each cycle it adds a fixed carrier tuning word and a scaled sample deviation to a phase accumulator. The accumulator MSB drives the RF output pin; the FM-band image is selected by external filtering.

## Interface
- ACC_WIDTH, 32, phase accumulator and tuning word width
- SAMPLE_WIDTH, 16, signed audio sample width
- DEV_SHIFT, 8, left shift applied to the sign-extended sample to form the deviation
- clock  input  1  109.5 MHz PLL output clock; all logic on the rising edge
- reset_n  input  1  reset, asynchronous and active-low
- enable  input  1  run request; tied to PLL locked and a user enable upstream
- carrier_word  input  ACC_WIDTH  centre-frequency phase increment; captured only on start
- sample  input  SAMPLE_WIDTH  signed two's-complement audio sample
- sample_valid  input  1  sample is presented
- sample_ready  output  1  block accepts a sample this cycle
- running  output  1  FSM is in RUN
- phase_out  output  8  top 8 bits of the phase accumulator, for debug and test
- rf_out  output  1  registered accumulator MSB

## Operation
- FSM states are IDLE, START and RUN.
- Reset (reset_n low, asynchronous) forces the following:
  - state = IDLE
  - carrier_q, sample_q, inc_q and phase all 0
  - rf_out, sample_ready and running all 0
- IDLE:
  - The accumulator is held at 0, rf_out = 0 and sample_ready = 0.
  - If enable = 1, go to START.
- START (exactly 1 cycle):
  - carrier_q <= carrier_word.
  - sample_q <= 0.
  - The state goes to RUN unconditionally. If enable has dropped, RUN exits on the following cycle.
- RUN:
  - sample_ready = 1 combinationally while in RUN; it has no dependence on sample_valid.
  - A handshake occurs when sample_valid & sample_ready; then sample_q <= sample.
  - Without a handshake, sample_q holds its last value. There is no underrun behaviour: the last sample repeats.
  - inc_q <= carrier_q + (sign_extend(sample_q, ACC_WIDTH) << DEV_SHIFT), computed modulo 2^ACC_WIDTH.
  - phase <= phase + inc_q, modulo 2^ACC_WIDTH. Natural wrap-around is required.
  - rf_out <= phase[ACC_WIDTH-1].
- Leaving RUN:
  - When enable = 0 in RUN, go to IDLE at the next edge.
  - On that edge, phase, inc_q and sample_q clear to 0 and rf_out <= 0.
  - carrier_q retains its value; it is reloaded on the next START.
- carrier_word changes while in RUN are ignored until the next IDLE→START.
- Deviation arithmetic:
  - Shift bits beyond ACC_WIDTH are discarded.
  - Sum overflow wraps and is not saturated.
  - Choosing DEV_SHIFT to keep the deviation in range is the integrator's responsibility.
- A sample presented in IDLE or START is not accepted (sample_ready = 0); the upstream must hold it.

## Timing
- Handshake in cycle N updates sample_q at edge N+1.
- inc_q reflects that sample at edge N+2.
- phase first advances by the new increment at edge N+3.
- rf_out reflects the resulting MSB at edge N+4.
- After START (edge S), the first nonzero inc_q = carrier_q is present at edge S+1.
- phase first becomes nonzero at edge S+2.
- enable low is sampled at edge E: running = 0, rf_out = 0 and phase_out = 0 after edge E.
- Asynchronous reset mid-RUN clears all outputs immediately, with no dependence on the clock.
- running = 1 exactly while state = RUN.

## Test plan
- Reset and idle:
  - Stimulus: assert reset_n = 0 mid-RUN, then release with enable = 0.
  - Required: rf_out, running, sample_ready and phase_out are 0 immediately and stay 0 for 100 cycles.
- Pure carrier:
  - Stimulus: carrier_word = 32'h4000_0000, no samples, enable = 1.
  - Required: phase_out steps 0x00, 0x40, 0x80, 0xC0 and repeats.
  - Required: rf_out has period 4 with a 50% duty cycle.
- Deviation and latency:
  - Stimulus: carrier_word = 32'h1000_0000, DEV_SHIFT = 8; in RUN, handshake sample = 16'h7FFF at cycle N.
  - Required: inc_q = 32'h1000_0000 + 32'h007F_FF00 = 32'h107F_FF00 from edge N+2.
  - Required: the phase delta equals that value from edge N+3.
- Negative sample and wrap:
  - Stimulus: carrier_word = 32'h0000_0100, sample = 16'h8000.
  - Required: inc_q = 32'hFF80_0100, the accumulator wraps modulo 2^32, and rf_out keeps toggling.
- Carrier capture:
  - Stimulus: change carrier_word while in RUN.
  - Required: the phase increment is unchanged.
  - Stimulus: drop enable for 1 cycle and raise it again.
  - Required: IDLE→START→RUN, with the new word used and phase restarted from 0.
- Handshake gating:
  - Stimulus: hold sample_valid = 1 with sample = 16'h1234 during IDLE and START.
  - Required: no acceptance until running = 1; sample_q holds 16'h1234 afterwards without further valids.
